// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: recovers pixel/line position from raw hsync/vsync and
// tracks whether the incoming timing matches the configured video mode.
module vga_timing_decoder #(
    parameter int unsigned H_WIDTH    = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_PULSE    = 96,
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned V_WIDTH    = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_TOTAL    = 525,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0,
    parameter int unsigned LOCK_LINES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       video_on,
    output logic       locked,
    output logic       err
);

    localparam int unsigned HW    = 10;
    localparam int unsigned VW    = 10;
    localparam int unsigned PERW  = 11;
    localparam int unsigned PULW  = 10;
    localparam int unsigned LINEW = 10;
    localparam int unsigned GOODW = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               hs_meta, hs, hs_prev;
    logic               vs_meta, vs, vs_prev;
    logic               hs_lead, vs_lead;
    logic [PERW-1:0]    period;
    logic [PULW-1:0]    pulse;
    logic [LINEW-1:0]   line_cnt;
    logic [GOODW-1:0]   good_cnt, good_cnt_next;
    logic               vs_armed, vs_armed_next;
    logic               err_next;
    logic               line_good, period_sat;
    logic [HW-1:0]      hcount_next;
    logic [VW-1:0]      vcount_next;

    // Two-flop synchronizers plus one previous-value flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_meta <= ~H_POL;
            hs      <= ~H_POL;
            hs_prev <= ~H_POL;
            vs_meta <= ~V_POL;
            vs      <= ~V_POL;
            vs_prev <= ~V_POL;
        end else begin
            hs_meta <= hsync_in;
            hs      <= hs_meta;
            hs_prev <= hs;
            vs_meta <= vsync_in;
            vs      <= vs_meta;
            vs_prev <= vs;
        end
    end

    assign hs_lead    = (hs == H_POL) && (hs_prev != H_POL);
    assign vs_lead    = (vs == V_POL) && (vs_prev != V_POL);
    assign period_sat = (period == '1);
    assign line_good  = (period == PERW'(H_TOTAL - 1)) && (pulse == PULW'(H_PULSE));

    // Line period, sync pulse width and lines-per-frame measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            period   <= '0;
            pulse    <= '0;
            line_cnt <= '0;
        end else begin
            if (hs_lead) begin
                period <= '0;
            end else if (!period_sat) begin
                period <= period + PERW'(1);
            end
            // The leading-edge cycle is itself an active cycle, so it counts as 1
            if (hs_lead) begin
                pulse <= PULW'(1);
            end else if ((hs == H_POL) && (pulse != '1)) begin
                pulse <= pulse + PULW'(1);
            end
            if (vs_lead) begin
                line_cnt <= hs_lead ? LINEW'(1) : LINEW'(0);
            end else if (hs_lead && (line_cnt != '1)) begin
                line_cnt <= line_cnt + LINEW'(1);
            end
        end
    end

    // Next raster position: sync edges realign, otherwise free-run with wrap
    always_comb begin
        hcount_next = hcount + HW'(1);
        vcount_next = vcount;
        if (hs_lead) begin
            hcount_next = HW'(H_WIDTH + H_FRONT);
        end else if (hcount == HW'(H_TOTAL - 1)) begin
            hcount_next = '0;
            vcount_next = (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + VW'(1);
        end
        if (vs_lead) begin
            vcount_next = VW'(V_WIDTH + V_FRONT);
        end
    end

    // Lock FSM: next state, good-line counting and error detection
    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        vs_armed_next = vs_armed;
        err_next      = 1'b0;
        unique case (state)
            SEARCH: begin
                if (hs_lead) begin
                    state_next    = TRACK;
                    good_cnt_next = '0;
                end
            end
            TRACK: begin
                if (hs_lead) begin
                    if (line_good) begin
                        good_cnt_next = good_cnt + GOODW'(1);
                        if (good_cnt_next == GOODW'(LOCK_LINES)) begin
                            state_next    = LOCKED;
                            good_cnt_next = '0;
                            vs_armed_next = 1'b0;
                        end
                    end else begin
                        err_next      = 1'b1;
                        good_cnt_next = '0;
                    end
                end else if (period_sat) begin
                    err_next   = 1'b1;
                    state_next = SEARCH;
                end
            end
            LOCKED: begin
                if ((hs_lead && !line_good) || (!hs_lead && period_sat)) begin
                    err_next = 1'b1;
                end
                // The first frame edge after locking only starts the frame count
                if (vs_lead) begin
                    if (!vs_armed) begin
                        vs_armed_next = 1'b1;
                    end else if (line_cnt != LINEW'(V_TOTAL)) begin
                        err_next = 1'b1;
                    end
                end
                if (err_next) begin
                    state_next = SEARCH;
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            good_cnt <= '0;
            vs_armed <= 1'b0;
            hcount   <= '0;
            vcount   <= '0;
            err      <= 1'b0;
            locked   <= 1'b0;
            video_on <= 1'b0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
            vs_armed <= vs_armed_next;
            hcount   <= hcount_next;
            vcount   <= vcount_next;
            err      <= err_next;
            locked   <= (state_next == LOCKED);
            video_on <= (state_next == LOCKED) && (hcount_next < HW'(H_WIDTH))
                        && (vcount_next < VW'(V_WIDTH));
        end
    end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Testbench for vga_timing_decoder: directed lock/unlock scenarios followed by
// randomized line timing, all compared against a timestamp-based reference model.
module tb_vga_timing_decoder;

    localparam int unsigned H_WIDTH    = 640;
    localparam int unsigned H_FRONT    = 16;
    localparam int unsigned H_PULSE    = 96;
    localparam int unsigned H_TOTAL    = 800;
    localparam int unsigned V_WIDTH    = 4;
    localparam int unsigned V_FRONT    = 1;
    localparam int unsigned V_TOTAL    = 6;
    localparam int unsigned LOCK_LINES = 4;
    localparam bit          HP         = 1'b0;
    localparam bit          VP         = 1'b0;
    localparam int          PER_SAT    = 2047;
    localparam int          PUL_SAT    = 1023;

    logic       clk = 1'b0;
    logic       rst;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       video_on;
    logic       locked;
    logic       err;

    vga_timing_decoder #(
        .H_WIDTH(H_WIDTH), .H_FRONT(H_FRONT), .H_PULSE(H_PULSE), .H_TOTAL(H_TOTAL),
        .V_WIDTH(V_WIDTH), .V_FRONT(V_FRONT), .V_TOTAL(V_TOTAL),
        .H_POL(HP), .V_POL(VP), .LOCK_LINES(LOCK_LINES)
    ) dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hcount(hcount), .vcount(vcount), .video_on(video_on),
        .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle)", tag, obs, exp);
        end
    endtask

    // Reference model state: timestamps of sync events, modular raster position
    int cyc = 0;
    bit started = 1'b0;
    bit h1, h2, h3, v1, v2, v3;
    int last_lead, last_trail, h_base, h_base_c;
    int m_mode, m_good, m_lines;
    bit m_armed;
    int m_h, m_v;
    bit m_err, m_locked, m_video;

    task automatic model_step();
        int c, period, pulse;
        bit hl, vl, good, sat, e;
        cyc++;
        if (rst) begin
            started    = 1'b1;
            last_lead  = cyc - 1;
            last_trail = cyc - 1;
            h_base     = 0;
            h_base_c   = cyc - 1;
            m_mode = 0; m_good = 0; m_lines = 0; m_armed = 1'b0;
            m_h = 0; m_v = 0; m_err = 1'b0; m_locked = 1'b0; m_video = 1'b0;
            h1 = ~HP; h2 = ~HP; h3 = ~HP;
            v1 = ~VP; v2 = ~VP; v3 = ~VP;
        end else begin
            c  = cyc - 1;
            hl = (h2 == HP) && (h3 != HP);
            vl = (v2 == VP) && (v3 != VP);
            if ((h2 != HP) && (h3 == HP)) last_trail = c;
            period = c - last_lead - 1;
            if (period > PER_SAT) period = PER_SAT;
            pulse = last_trail - last_lead;
            if (pulse > PUL_SAT) pulse = PUL_SAT;
            good = (period == int'(H_TOTAL) - 1) && (pulse == int'(H_PULSE));
            sat  = (period == PER_SAT);
            e    = 1'b0;
            case (m_mode)
                0: if (hl) begin m_mode = 1; m_good = 0; end
                1: begin
                    if (hl) begin
                        if (good) begin
                            m_good++;
                            if (m_good == int'(LOCK_LINES)) begin m_mode = 2; m_armed = 1'b0; end
                        end else begin
                            e = 1'b1; m_good = 0;
                        end
                    end else if (sat) begin
                        e = 1'b1; m_mode = 0;
                    end
                end
                default: begin
                    if ((hl && !good) || (!hl && sat)) e = 1'b1;
                    if (vl) begin
                        if (!m_armed) m_armed = 1'b1;
                        else if (m_lines != int'(V_TOTAL)) e = 1'b1;
                    end
                    if (e) m_mode = 0;
                end
            endcase
            if (vl) m_lines = 0;
            if (hl) m_lines++;
            if (hl) begin
                last_lead = c;
                h_base    = int'(H_WIDTH + H_FRONT);
                h_base_c  = c;
            end
            m_h = (h_base + c - h_base_c) % int'(H_TOTAL);
            if (vl) m_v = int'(V_WIDTH + V_FRONT);
            else if (!hl && m_h == 0) m_v = (m_v + 1) % int'(V_TOTAL);
            m_err    = e;
            m_locked = (m_mode == 2);
            m_video  = m_locked && (m_h < int'(H_WIDTH)) && (m_v < int'(V_WIDTH));
            h3 = h2; h2 = h1; h1 = hsync_in;
            v3 = v2; v2 = v1; v1 = vsync_in;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Stimulus bookkeeping shared with the monitor (single writer each)
    int fline = 0;
    int frame_len = V_TOTAL;
    int fall_cyc = -10;
    int rst_chk_cyc = -10;
    int err_total = 0;
    int video_total = 0;
    int last_rise_cyc = -1;
    bit prev_locked = 1'b0;

    // Compare every cycle against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("hcount", int'(hcount), m_h);
            check("vcount", int'(vcount), m_v);
            check("locked", int'(locked), int'(m_locked));
            check("err", int'(err), int'(m_err));
            check("video_on", int'(video_on), int'(m_video));
            if (err) err_total++;
            if (video_on) video_total++;
            if (locked && !prev_locked) last_rise_cyc = cyc;
            prev_locked = locked;
            if (cyc == fall_cyc + 3) check("lat656", int'(hcount), 656);
            if (cyc == rst_chk_cyc) begin
                check("rst_hcount", int'(hcount), 0);
                check("rst_vcount", int'(vcount), 0);
                check("rst_locked", int'(locked), 0);
                check("rst_err", int'(err), 0);
                check("rst_video", int'(video_on), 0);
            end
        end
    end

    task automatic drive_line(input int period, input int pulse, input int rst_at);
        bit vact;
        vact = (fline == 0);
        for (int i = 0; i < period; i++) begin
            @(posedge clk);
            #1;
            hsync_in = (i < pulse) ? HP : ~HP;
            vsync_in = vact ? VP : ~VP;
            rst      = (i == rst_at);
            if (i == 0) fall_cyc = cyc;
            if (i == rst_at) rst_chk_cyc = cyc + 1;
        end
        fline++;
        if (fline >= frame_len) fline = 0;
    endtask

    task automatic drive_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            hsync_in = ~HP;
            vsync_in = ~VP;
            rst      = 1'b0;
        end
    endtask

    initial begin
        int base, vbase, f;
        rst      = 1'b1;
        hsync_in = ~HP;
        vsync_in = ~VP;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("init_hcount", int'(hcount), 0);
        check("init_locked", int'(locked), 0);
        check("init_err", int'(err), 0);

        // Clean stream: lock on the 5th edge, no errors, exact visible-cycle count
        base = err_total;
        vbase = 0;
        f = 0;
        for (int l = 0; l < 18; l++) begin
            drive_line(H_TOTAL, H_PULSE, -1);
            if (l == 4) f = fall_cyc;
            if (l == 11) vbase = video_total;
        end
        check("clean_locked", int'(locked), 1);
        check("clean_errs", err_total - base, 0);
        check("clean_rise", last_rise_cyc, f + 3);
        check("clean_video", video_total - vbase, int'(H_WIDTH * V_WIDTH));

        // One frame one line short
        base = err_total;
        frame_len = V_TOTAL - 1;
        repeat (V_TOTAL - 1) drive_line(H_TOTAL, H_PULSE, -1);
        frame_len = V_TOTAL;
        drive_line(H_TOTAL, H_PULSE, -1);
        check("short_frame_errs", err_total - base, 1);
        check("short_frame_locked", int'(locked), 0);
        repeat (5) drive_line(H_TOTAL, H_PULSE, -1);
        check("short_frame_relock", int'(locked), 1);

        // One 801-clock line
        base = err_total;
        drive_line(H_TOTAL + 1, H_PULSE, -1);
        drive_line(H_TOTAL, H_PULSE, -1);
        check("long_line_errs", err_total - base, 1);
        check("long_line_locked", int'(locked), 0);
        for (int l = 0; l < 5; l++) begin
            drive_line(H_TOTAL, H_PULSE, -1);
            if (l == 4) f = fall_cyc;
        end
        check("long_line_relock", int'(locked), 1);
        check("long_line_rise", last_rise_cyc, f + 3);

        // hsync stuck inactive past period saturation
        base = err_total;
        drive_gap(2100);
        check("stuck_errs", err_total - base, 1);
        check("stuck_locked", int'(locked), 0);
        repeat (6) drive_line(H_TOTAL, H_PULSE, -1);
        check("stuck_relock", int'(locked), 1);

        // One-cycle reset mid-line while locked
        drive_line(H_TOTAL, H_PULSE, 400);
        check("rst_mid_locked", int'(locked), 0);
        repeat (5) drive_line(H_TOTAL, H_PULSE, -1);
        check("rst_mid_relock", int'(locked), 1);

        // Randomized line timing, frame lengths and resets
        for (int l = 0; l < 24; l++) begin
            int r, per, pul, ra;
            r   = int'($urandom_range(0, 9));
            per = H_TOTAL;
            pul = H_PULSE;
            ra  = -1;
            case (r)
                0: per = H_TOTAL + int'($urandom_range(1, 3));
                1: per = H_TOTAL - int'($urandom_range(1, 3));
                2: pul = ($urandom_range(0, 1) == 0) ? H_PULSE - 1 : H_PULSE + 1;
                3: ra = int'($urandom_range(100, 700));
                4: if (fline == 0) frame_len = int'($urandom_range(V_TOTAL - 1, V_TOTAL + 1));
                default: ;
            endcase
            drive_line(per, pul, ra);
        end
        drive_gap(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
